// File: rtl/violation_responder.sv
// Violation responder: buffers shadow-stack violation/interrupt events in a FIFO,
// raises a level IRQ to the CPU and serves register reads of the head entry.
module violation_responder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        violation_i,
    input  logic        interrupt_i,
    input  logic [31:0] expected_addr_i,
    input  logic [31:0] actual_addr_i,
    input  logic [2:0]  fsm_state_i,
    input  logic        rd_req_i,
    input  logic [1:0]  rd_sel_i,
    input  logic        pop_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        irq_o
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  DROP_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_e;

    typedef struct packed {
        logic [1:0]  cause;
        logic [2:0]  fsm;
        logic [31:0] exp_addr;
        logic [31:0] act_addr;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    state_e              state_q, state_d;
    logic                irq_q, irq_d;
    logic                rd_valid_q, rd_valid_d;
    logic [31:0]         rd_data_q, rd_data_d;

    logic   capture, empty, full, pop_en, wr_en, drop, clr_drop;
    entry_t head, wr_entry;
    logic [31:0] status;

    // FIFO control: a pop frees the slot a same-cycle capture needs when full
    always_comb begin
        capture  = violation_i | interrupt_i;
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop_en   = pop_i & ~empty;
        wr_en    = capture & (~full | pop_en);
        drop     = capture & full & ~pop_en;
        clr_drop = rd_req_i & (rd_sel_i == 2'd3);
        head     = mem_q[rd_ptr_q];
        wr_entry = '{cause: {interrupt_i, violation_i}, fsm: fsm_state_i,
                     exp_addr: expected_addr_i, act_addr: actual_addr_i};

        wr_ptr_d = wr_en  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + FCNT_W'(wr_en) - FCNT_W'(pop_en);

        drop_cnt_d = drop_cnt_q;
        if (clr_drop) begin
            drop_cnt_d = '0;
        end else if (drop && drop_cnt_q != DROP_MAX) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Read path: data reflects the head as it stood in the request cycle
    always_comb begin
        status = {5'(count_q), full, empty, (drop_cnt_q != '0),
                  (empty ? 3'd0 : head.fsm), 19'd0,
                  (empty ? 2'd0 : head.cause)};
        rd_valid_d = rd_req_i;
        rd_data_d  = '0;
        if (rd_req_i) begin
            case (rd_sel_i)
                2'd0:    rd_data_d = status;
                2'd1:    rd_data_d = empty ? 32'd0 : head.exp_addr;
                2'd2:    rd_data_d = empty ? 32'd0 : head.act_addr;
                default: rd_data_d = 32'(drop_cnt_q);
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (pop_en) begin
                    state_d = (count_d != '0) ? ST_ASSERT : ST_IDLE;
                end else if (rd_req_i && rd_sel_i == 2'd0) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (pop_en) state_d = (count_d != '0) ? ST_ASSERT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Entry storage needs no reset; the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_violation_responder.sv
// Bench for violation_responder: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_violation_responder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        violation_i, interrupt_i;
    logic [31:0] expected_addr_i, actual_addr_i;
    logic [2:0]  fsm_state_i;
    logic        rd_req_i;
    logic [1:0]  rd_sel_i;
    logic        pop_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    violation_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .violation_i(violation_i), .interrupt_i(interrupt_i),
        .expected_addr_i(expected_addr_i), .actual_addr_i(actual_addr_i),
        .fsm_state_i(fsm_state_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
        .pop_i(pop_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        viol, intr;
        logic [31:0] ea, aa;
        logic [2:0]  fs;
        logic        rd;
        logic [1:0]  sel;
        logic        pop;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_irq;
    } vec_t;

    typedef struct packed {
        logic [1:0]  cause;
        logic [2:0]  fs;
        logic [31:0] ea, aa;
    } mentry_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic i, input logic [31:0] ea,
                                input logic [31:0] aa, input logic [2:0] fs,
                                input logic rd, input logic [1:0] sel, input logic p,
                                input logic ev, input logic [31:0] ed, input logic eirq);
        vec_t r;
        r.viol = v; r.intr = i; r.ea = ea; r.aa = aa; r.fs = fs;
        r.rd = rd; r.sel = sel; r.pop = p;
        r.e_valid = ev; r.e_data = ed; r.e_irq = eirq;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic i, input logic [31:0] ea,
                         input logic [31:0] aa, input logic [2:0] fs,
                         input logic rd, input logic [1:0] sel, input logic p);
        @(negedge clk);
        violation_i = v; interrupt_i = i; expected_addr_i = ea; actual_addr_i = aa;
        fsm_state_i = fs; rd_req_i = rd; rd_sel_i = sel; pop_i = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_out(input string name, input logic ev, input logic [31:0] ed,
                             input logic eirq);
        check({name, ".valid"}, 32'(rd_valid_o), 32'(ev));
        check({name, ".data"}, rd_data_o, ed);
        check({name, ".irq"}, 32'(irq_o), 32'(eirq));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        violation_i = 0; interrupt_i = 0; expected_addr_i = 0; actual_addr_i = 0;
        fsm_state_i = 0; rd_req_i = 0; rd_sel_i = 0; pop_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model state
    mentry_t mq[$];
    int      m_drop;
    bit      m_service;

    function automatic logic [31:0] model_read(input logic [1:0] sel);
        logic [31:0] r;
        int sz;
        sz = mq.size();
        r = 32'd0;
        case (sel)
            2'd0: begin
                r = 32'(sz) << 27;
                if (sz == DEPTH) r = r | 32'h0400_0000;
                if (sz == 0)     r = r | 32'h0200_0000;
                if (m_drop != 0) r = r | 32'h0100_0000;
                if (sz > 0)      r = r | (32'(mq[0].fs) << 21) | 32'(mq[0].cause);
            end
            2'd1: if (sz > 0) r = mq[0].ea;
            2'd2: if (sz > 0) r = mq[0].aa;
            default: r = 32'(m_drop);
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] e_data;
        logic        e_irq;
        logic        v, i, rd, p;
        logic [1:0]  sel;
        logic [2:0]  fs;
        logic [31:0] ea, aa;
        bit          asserted_pre;
        mentry_t     ne;

        do_reset();
        #1;
        check_out("reset", 0, 0, 0);

        // Basic capture and field reads
        tbl.push_back(mk(1,0,32'h1000,32'h2000,3, 0,0,0, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0, 1,32'h0000_1000,1));
        tbl.push_back(mk(0,0,0,0,0, 1,2,0, 1,32'h0000_2000,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h0860_0001,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,0));
        // Both causes in one cycle
        tbl.push_back(mk(1,1,32'hA,32'hB,5, 0,0,0, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h08A0_0003,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,0));
        // Six events into a four-deep FIFO
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1,0,32'h100+32'(k),32'h200+32'(k),3'(k), 0,0,0, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h2500_0001,0));
        tbl.push_back(mk(0,0,0,0,0, 1,3,0, 1,32'h2,0));
        tbl.push_back(mk(0,0,0,0,0, 1,3,0, 1,32'h0,0));
        // Full with pop and capture together
        tbl.push_back(mk(1,0,32'hDEAD,32'hBEEF,7, 0,0,1, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,3,0, 1,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h2420_0001,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0, 1,32'h0000_DEAD,1));
        tbl.push_back(mk(0,0,0,0,0, 1,2,0, 1,32'h0000_BEEF,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h08E0_0001,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,0));
        // Empty FIFO: fields read zero, pop ignored
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h0200_0000,0));
        tbl.push_back(mk(0,0,0,0,0, 1,1,0, 1,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,32'h0200_0000,0));

        foreach (tbl[n]) begin
            apply(tbl[n].viol, tbl[n].intr, tbl[n].ea, tbl[n].aa, tbl[n].fs,
                  tbl[n].rd, tbl[n].sel, tbl[n].pop);
            check_out($sformatf("vec%0d", n), tbl[n].e_valid, tbl[n].e_data, tbl[n].e_irq);
        end

        // Service handshake: IRQ stays low on new events until a pop
        apply(1,0,32'h11,32'h22,0, 0,0,0); check_out("svc.event1", 0, 0, 1);
        apply(0,0,0,0,0, 1,0,0);            check_out("svc.status", 1, 32'h0800_0001, 0);
        apply(1,0,32'h33,32'h44,0, 0,0,0); check_out("svc.event2", 0, 0, 0);
        idle();                             check_out("svc.hold", 0, 0, 0);
        apply(0,0,0,0,0, 0,0,1);            check_out("svc.pop1", 0, 0, 1);
        apply(0,0,0,0,0, 1,0,0);            check_out("svc.count1", 1, 32'h0800_0001, 0);
        apply(0,0,0,0,0, 0,0,1);            check_out("svc.pop2", 0, 0, 0);
        idle();                             check_out("svc.idle", 0, 0, 0);

        // Reset lands while a read is in flight; pulses during reset are ignored
        for (int k = 0; k < 3; k++) apply(1,0,32'h50+32'(k),32'h60,1, 0,0,0);
        apply(0,0,0,0,0, 1,0,0);
        reset = 1'b1;
        rd_req_i = 0;
        #1;
        check_out("rst.kill", 0, 0, 0);
        @(negedge clk);
        violation_i = 1; interrupt_i = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_out("rst.held", 0, 0, 0);
        end
        reset = 1'b0;
        violation_i = 0; interrupt_i = 0;
        idle(); check_out("rst.post1", 0, 0, 0);
        idle(); check_out("rst.post2", 0, 0, 0);
        apply(0,0,0,0,0, 1,0,0); check_out("rst.status", 1, 32'h0200_0000, 0);

        // Randomized run against the reference model
        do_reset();
        mq.delete();
        m_drop = 0;
        m_service = 0;
        for (int n = 0; n < 1500; n++) begin
            v   = ($urandom_range(0, 3) == 0);
            i   = ($urandom_range(0, 3) == 0);
            ea  = $urandom;
            aa  = $urandom;
            fs  = 3'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 2) == 0);
            sel = 2'($urandom_range(0, 3));
            p   = ($urandom_range(0, 3) == 0);

            e_data = rd ? model_read(sel) : 32'd0;
            asserted_pre = (mq.size() > 0) && !m_service;
            if (p && mq.size() > 0) begin
                void'(mq.pop_front());
                m_service = 0;
            end else if (rd && sel == 2'd0 && asserted_pre) begin
                m_service = 1;
            end
            if (v || i) begin
                if (mq.size() < DEPTH) begin
                    ne.cause = {i, v}; ne.fs = fs; ne.ea = ea; ne.aa = aa;
                    mq.push_back(ne);
                end else if (m_drop < (1 << CNT_W) - 1) begin
                    m_drop++;
                end
            end
            if (rd && sel == 2'd3) m_drop = 0;
            e_irq = (mq.size() > 0) && !m_service;

            apply(v, i, ea, aa, fs, rd, sel, p);
            check_out($sformatf("rand%0d", n), rd, e_data, e_irq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
